// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps the l2mux selects through all eight channels, samples y8 at the end
// of each settle window and hands the assembled byte downstream over valid/ready.
module mux_scan_ctrl #(
    parameter int SETTLE = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_cont,
    input  logic       i_y8,
    input  logic       i_out_ready,
    output logic       o_sabcd,
    output logic       o_sxy,
    output logic       o_sz,
    output logic       o_busy,
    output logic       o_out_valid,
    output logic [7:0] o_data
);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0] ONE = CW'(1);
    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;
    state_t r_state, w_state_nxt;
    logic [2:0] r_idx, w_idx_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [7:0] r_data, w_data_nxt;
    logic w_last;
    assign w_last = (r_cnt == LAST);
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_idx   <= 3'd0;
            r_cnt   <= '0;
            r_data  <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_data  <= w_data_nxt;
        end
    end
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_data_nxt  = r_data;
        case (r_state)
            IDLE: begin
                w_idx_nxt = 3'd0;
                w_cnt_nxt = '0;
                if (i_start) w_state_nxt = SCAN;
            end
            SCAN: begin
                if (w_last) begin
                    w_data_nxt[r_idx] = i_y8;
                    w_cnt_nxt = '0;
                    w_idx_nxt = (r_idx == 3'd7) ? 3'd0 : r_idx + 3'd1;
                    if (r_idx == 3'd7) w_state_nxt = HOLD;
                end else begin
                    w_cnt_nxt = r_cnt + ONE;
                end
            end
            HOLD: begin
                // cont only matters on the accepting edge; otherwise the word just sits here
                if (i_out_ready) w_state_nxt = i_cont ? SCAN : IDLE;
                w_idx_nxt = 3'd0;
                w_cnt_nxt = '0;
            end
            default: w_state_nxt = IDLE;
        endcase
    end
    assign o_sabcd     = r_idx[0];
    assign o_sxy       = r_idx[1];
    assign o_sz        = r_idx[2];
    assign o_busy      = (r_state == SCAN);
    assign o_out_valid = (r_state == HOLD);
    assign o_data      = r_data;
endmodule
